// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer read path: address width,
// default burst length, responder FSM states and burst alignment.
package vga_pkg;

    localparam int ADDR_W        = 26;
    localparam int DEF_BURST_LEN = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } fb_state_e;

    // Clear the byte-offset bits covered by one burst of 32-bit words.
    function automatic logic [ADDR_W-1:0] burst_align(
        input logic [ADDR_W-1:0] addr,
        input int                burst_len
    );
        logic [ADDR_W-1:0] span_mask;
        span_mask = ADDR_W'(burst_len * 4 - 1);
        return addr & ~span_mask;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: byte-enabled write port and a registered,
// read-first read port. Shaped so a vendor block-RAM macro can drop in.
module fb_ram #(
    parameter int WORDS = 16384,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wbe,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Both ports in one block with non-blocking updates: a same-cycle read of
    // the word being written returns the previous contents.
    always_ff @(posedge clock) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/vga_fb_responder.sv
// Block-RAM stand-in for the SDRAM arbiter's VGA burst-read port; the CPU
// fills the framebuffer through a byte-enabled write port.
module vga_fb_responder
    import vga_pkg::*;
#(
    parameter int MEM_WORDS    = 16384,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              request,
    output logic              ready,
    input  logic [ADDR_W-1:0] address,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] raddress,
    output logic              complete,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_byte_en
);

    localparam int MEM_AW   = $clog2(MEM_WORDS);
    localparam int BEAT_W   = $clog2(BURST_LEN);
    localparam int LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int LAT_INIT = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    fb_state_e         state;
    logic [ADDR_W-1:0] base;
    logic [BEAT_W-1:0] beat;
    logic [LAT_W-1:0]  lat_cnt;

    logic              issue;
    logic              last_issue;
    logic [ADDR_W-1:0] issue_addr;
    logic [31:0]       ram_q;
    logic              unused_wr_bits;

    // STREAM cycles issue RAM reads; the beat outputs trail them by one cycle,
    // which is why WAIT lasts READ_LATENCY-1 cycles rather than READ_LATENCY.
    assign issue      = (state == STREAM);
    assign last_issue = issue && (beat == BEAT_W'(BURST_LEN - 1));
    assign issue_addr = base + ADDR_W'({beat, 2'b00});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ready    <= 1'b0;
            base     <= '0;
            beat     <= '0;
            lat_cnt  <= '0;
            rvalid   <= 1'b0;
            raddress <= '0;
            complete <= 1'b0;
        end else begin
            ready    <= 1'b0;
            rvalid   <= issue;
            raddress <= issue ? issue_addr : '0;
            complete <= last_issue;

            case (state)
                IDLE: begin
                    if (request) begin
                        ready   <= 1'b1;
                        base    <= burst_align(address, BURST_LEN);
                        beat    <= '0;
                        lat_cnt <= LAT_W'(LAT_INIT);
                        state   <= (READ_LATENCY == 1) ? STREAM : WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= STREAM;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                STREAM: begin
                    beat <= beat + BEAT_W'(1);
                    if (last_issue) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fb_ram #(
        .WORDS (MEM_WORDS),
        .AW    (MEM_AW)
    ) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_address[MEM_AW+1:2]),
        .wdata (wr_data),
        .wbe   (wr_byte_en),
        .re    (issue),
        .raddr (issue_addr[MEM_AW+1:2]),
        .rdata (ram_q)
    );

    // The RAM output holds stale data between bursts; keep the bus quiet.
    assign rdata = rvalid ? ram_q : '0;

    // Writes alias modulo the framebuffer size and ignore the byte offset.
    assign unused_wr_bits = ^{wr_address[ADDR_W-1:MEM_AW+2], wr_address[1:0]};

endmodule
